tv_checker: RTL and testbench

TV_CHECKER -- requirements
Module: tv_checker

---
 rtl/tv_checker.sv | 131 +++++++++++++
 tb/tb_tv_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tv_checker.sv
// Gate-level test-vector checker: syncs to a 00->01->10->11 sweep,
// compares dut_out to the selected gate and reports a run verdict.
module tv_checker #(
    parameter int NUM_SWEEPS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    input  logic             in0,
    input  logic             in1,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       fail_mask,
    output logic             seq_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [2:0]       gsel;
    logic [3:0]       sweep_cnt;
    logic [2:0]       to_cnt;
    logic [1:0]       exp_vec;

    logic [1:0]       vec;
    logic             exp_bit;
    logic             mis;
    logic             ord_bad;
    logic             last;
    logic [CNT_W-1:0] err_nxt;
    logic [3:0]       fm_nxt;

    assign busy = (state == S_SYNC) || (state == S_CHECK);
    assign done = (state == S_DONE);

    always_comb begin
        vec     = {in1, in0};
        exp_bit = 1'b0;
        case (gsel)
            3'b000:  exp_bit = in0 & in1;
            3'b001:  exp_bit = in0 | in1;
            3'b010:  exp_bit = ~(in0 & in1);
            3'b011:  exp_bit = ~(in0 | in1);
            3'b100:  exp_bit = in0 ^ in1;
            3'b101:  exp_bit = ~(in0 ^ in1);
            3'b110:  exp_bit = in0;
            default: exp_bit = ~in0;
        endcase
        mis     = dut_out ^ exp_bit;
        ord_bad = (vec != exp_vec);
        last    = (vec == 2'b11) &&
                  (sweep_cnt == 4'(NUM_SWEEPS - 1));
        err_nxt = err_cnt;
        if (mis && (err_cnt != {CNT_W{1'b1}}))
            err_nxt = err_cnt + CNT_W'(1);
        fm_nxt = fail_mask;
        if (mis)
            fm_nxt[vec] = 1'b1;
    end

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gsel      <= 3'd0;
            err_cnt   <= '0;
            fail_mask <= 4'd0;
            seq_err   <= 1'b0;
            pass      <= 1'b0;
            sweep_cnt <= 4'd0;
            to_cnt    <= 3'd0;
            exp_vec   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SYNC;
                        gsel      <= gate_sel;
                        err_cnt   <= '0;
                        fail_mask <= 4'd0;
                        seq_err   <= 1'b0;
                        pass      <= 1'b0;
                        sweep_cnt <= 4'd0;
                        to_cnt    <= 3'd0;
                        exp_vec   <= 2'd0;
                    end
                end
                S_SYNC: begin
                    if (vec == 2'b00) begin
                        err_cnt   <= err_nxt;
                        fail_mask <= fm_nxt;
                        exp_vec   <= 2'b01;
                        state     <= S_CHECK;
                    end else if (to_cnt == 3'd7) begin
                        seq_err <= 1'b1;
                        pass    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    err_cnt   <= err_nxt;
                    fail_mask <= fm_nxt;
                    exp_vec   <= vec + 2'd1;
                    if (ord_bad)
                        seq_err <= 1'b1;
                    if (vec == 2'b11)
                        sweep_cnt <= sweep_cnt + 4'd1;
                    // verdict includes this edge's mismatch and order result
                    if (last) begin
                        pass  <= (err_nxt == '0) && !seq_err && !ord_bad;
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (!start)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv_checker.sv
// Bench for tv_checker: directed scenarios plus randomized sweeps
// scored against a vector-stream model.
module tb_tv_checker;

    localparam int NS = 4;

    logic       div_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       start   = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       in0 = 1'b0;
    logic       in1 = 1'b0;
    logic       dut_out = 1'b0;
    logic       busy, done, pass, seq_err;
    logic [7:0] err_cnt;
    logic [3:0] fail_mask;

    int checks   = 0;
    int failures = 0;

    logic [1:0] vq[$];
    logic       dq[$];

    tv_checker #(.NUM_SWEEPS(NS), .CNT_W(8)) dut (
        .div_clk(div_clk), .rst(rst), .start(start),
        .gate_sel(gate_sel), .in0(in0), .in1(in1),
        .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt),
        .fail_mask(fail_mask), .seq_err(seq_err)
    );

    always #5 div_clk = ~div_clk;

    function automatic logic gfun(logic [2:0] g, logic [1:0] v);
        case (g)
            3'd0: return v[0] & v[1];
            3'd1: return v[0] | v[1];
            3'd2: return !(v[0] & v[1]);
            3'd3: return !(v[0] | v[1]);
            3'd4: return v[0] ^ v[1];
            3'd5: return !(v[0] ^ v[1]);
            3'd6: return v[0];
            default: return !v[0];
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(int phase, int len);
        vq.delete();
        for (int k = 0; k < len; k++)
            vq.push_back(2'((phase + k) % 4));
    endtask

    task automatic outs(logic [2:0] g, int err_pct, bit stuck0);
        dq.delete();
        for (int k = 0; k < vq.size(); k++) begin
            if (stuck0)
                dq.push_back(1'b0);
            else
                dq.push_back(gfun(g, vq[k]) ^
                             ($urandom_range(0, 99) < err_pct));
        end
    endtask

    // vq[0] is the start-capture sample and is never scored
    task automatic model(input logic [2:0] g, output int di,
                         output int ec, output logic [3:0] fm,
                         output logic se);
        int i, miss, sw;
        logic [1:0] nx;
        di = -1; ec = 0; fm = 4'd0; se = 1'b0;
        miss = 0; sw = 0; i = 1; nx = 2'b00;
        while (i < vq.size() && vq[i] != 2'b00) begin
            miss++;
            if (miss == 8) begin
                se = 1'b1; di = i;
                return;
            end
            i++;
        end
        while (i < vq.size()) begin
            if (vq[i] != nx) se = 1'b1;
            if (dq[i] !== gfun(g, vq[i])) begin
                if (ec < 255) ec++;
                fm[vq[i]] = 1'b1;
            end
            nx = vq[i] + 2'd1;
            if (vq[i] == 2'b11) begin
                sw++;
                if (sw == NS) begin
                    di = i;
                    return;
                end
            end
            i++;
        end
    endtask

    task automatic run(string nm, logic [2:0] g, int fixed_idx);
        int di, ec, got;
        logic [3:0] fm;
        logic se;
        model(g, di, ec, fm, se);
        got = -1;
        gate_sel = g;
        start = 1'b1;
        for (int k = 0; k < vq.size(); k++) begin
            {in1, in0} = vq[k];
            dut_out = dq[k];
            if (k == 1) gate_sel = ~g;
            @(negedge div_clk);
            if (k == 0) chk({nm, "_busy"}, 32'(busy), 1);
            if (done) begin
                got = k;
                break;
            end
        end
        chk({nm, "_done_idx"}, got, di);
        if (fixed_idx >= 0) chk({nm, "_idx_fixed"}, got, fixed_idx);
        chk({nm, "_err_cnt"}, 32'(err_cnt), ec);
        chk({nm, "_fail_mask"}, 32'(fail_mask), 32'(fm));
        chk({nm, "_seq_err"}, 32'(seq_err), 32'(se));
        chk({nm, "_pass"}, 32'(pass), 32'(ec == 0 && !se));
        chk({nm, "_busy_done"}, 32'(busy), 0);
        start = 1'b0;
        @(negedge div_clk);
        chk({nm, "_idle_done"}, 32'(done), 0);
        chk({nm, "_held_err"}, 32'(err_cnt), ec);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_pass"}, 32'(pass), 0);
        chk({nm, "_err"}, 32'(err_cnt), 0);
        chk({nm, "_mask"}, 32'(fail_mask), 0);
        chk({nm, "_seq"}, 32'(seq_err), 0);
    endtask

    initial begin
        logic [1:0] v;
        logic [2:0] g;
        #12;
        chk_zero("reset");
        @(negedge div_clk);
        rst = 1'b1;
        @(negedge div_clk);

        build(3, 40); outs(3'd0, 0, 0);
        run("clean", 3'd0, 16);

        build(0, 40); outs(3'd4, 0, 1);
        run("stuck", 3'd4, -1);
        chk("stuck_err8", 32'(err_cnt), 8);
        chk("stuck_mask", 32'(fail_mask), 32'h6);

        build(2, 40); outs(3'd5, 0, 0);
        run("late", 3'd5, 17);

        build(3, 40); vq.delete(3); outs(3'd0, 0, 0);
        run("order", 3'd0, -1);
        chk("order_seq", 32'(seq_err), 1);
        chk("order_err", 32'(err_cnt), 0);

        vq.delete();
        for (int k = 0; k < 20; k++) vq.push_back(2'b01);
        outs(3'd1, 0, 0);
        run("timeout", 3'd1, 8);

        build(0, 40); outs(3'd2, 50, 0);
        gate_sel = 3'd2;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            {in1, in0} = vq[k];
            dut_out = dq[k];
            @(negedge div_clk);
        end
        #2 rst = 1'b0;
        #1 chk_zero("midrst");
        start = 1'b0;
        @(negedge div_clk);
        rst = 1'b1;
        @(negedge div_clk);
        build(3, 40); outs(3'd2, 0, 0);
        run("post_rst", 3'd2, 16);

        repeat (6) begin
            g = 3'($urandom_range(0, 7));
            v = 2'($urandom_range(0, 3));
            vq.delete();
            for (int k = 0; k < 80; k++) begin
                vq.push_back(v);
                v = v + (($urandom_range(0, 99) < 8) ? 2'd2 : 2'd1);
            end
            outs(g, 15, 0);
            run("rand", g, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
